multdiv: RTL and testbench

Multi-cycle multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline. It computes MULT, MULTU, DIV and DIVU results for the HI/LO registers. It drives `ok`, which the hazard unit consumes as `mult_ok`: Execute is stalled while `ok` is 0. Results are forwarded to the HI/LO writeback path with the instruction when it leaves Execute.

---
 rtl/multdiv.sv | 167 ++++++++++++++++
 tb/tb_multdiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the Execute stage; drives ok (mult_ok) to stall Execute.
// Optional MULTDIV_DIVZERO_FAST_EN: divide by zero completes straight from IDLE to DONE.
module multdiv #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hold,
  input  logic        flush,
  output logic        ok,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Handshake: valid is held while Execute stalls; the op is accepted in IDLE
  // when valid & ~flush, and ok=1 marks "result valid or nothing pending".
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [5:0]  cnt;

  logic        div_signed;
  logic [31:0] a_mag, b_mag;

  logic [1:0]         mul_op;
  logic [31:0]        mul_a, mul_b;
  logic signed [32:0] mul_a_ext, mul_b_ext;
  logic signed [65:0] prod_full;
  logic [63:0]        prod;

  logic [32:0] rem_sh, trial;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    div_signed = ~op[0];
    a_mag = (div_signed && a[31]) ? -a : a;
    b_mag = (div_signed && b[31]) ? -b : b;
  end

  // In IDLE the raw inputs feed the multiplier so a single-cycle multiply can finish at accept.
  always_comb begin
    mul_op    = (state == IDLE) ? op : op_q;
    mul_a     = (state == IDLE) ? a  : a_q;
    mul_b     = (state == IDLE) ? b  : b_q;
    mul_a_ext = {~mul_op[0] & mul_a[31], mul_a};
    mul_b_ext = {~mul_op[0] & mul_b[31], mul_b};
    prod_full = mul_a_ext * mul_b_ext;
    prod      = prod_full[63:0];
  end

  // One restoring step; bit 32 of the trial is the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[32]) begin
      rem_nx = trial[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
    q_fix = (~op_q[0] && (a_q[31] ^ b_q[31])) ? -quo_nx : quo_nx;
    r_fix = (~op_q[0] && a_q[31]) ? -rem_nx : rem_nx;
  end

  always_comb begin
    ok = 1'b1;
    case (state)
      IDLE:     ok = ~valid;
      MUL, DIV: ok = flush;
      DONE:     ok = 1'b1;
      default:  ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 2'b00;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            cnt   <= '0;
            if (op[1]) begin
`ifdef MULTDIV_DIVZERO_FAST_EN
              if (b == 32'd0) begin
                hi    <= a;
                lo    <= 32'hFFFF_FFFF;
                state <= DONE;
              end else begin
                state <= DIV;
              end
`else
              state <= DIV;
`endif
            end else if (MUL_CYCLES == 1) begin
              hi    <= prod[63:32];
              lo    <= prod[31:0];
              state <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (int'(cnt) == MUL_CYCLES - 2) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt == 6'd31) begin
            // Divide by zero bypasses the fix-up: quotient all ones, remainder is the dividend.
            if (b_q == 32'd0) begin
              hi <= a_q;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (!hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed and random ops against a scoreboard of {hi, lo}.
module tb_multdiv;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_LAT    = 33;
`ifdef MULTDIV_DIVZERO_FAST_EN
  localparam int DIVZ_LAT = 1;
`else
  localparam int DIVZ_LAT = 33;
`endif

  logic        clk;
  logic        reset;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hold;
  logic        flush;
  logic        ok;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prev_hi, prev_lo;

  multdiv #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .hold(hold), .flush(flush), .ok(ok), .hi(hi), .lo(lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy;
    logic [31:0] mx, my, q, r;
    if (!o[1]) begin
      if (!o[0]) begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
      end
      return {32'd0, x} * {32'd0, y};
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o[0]) return {x % y, x / y};
    mx = x[31] ? -x : x;
    my = y[31] ? -y : y;
    q = mx / my;
    r = mx % my;
    if (x[31] ^ y[31]) q = -q;
    if (x[31]) r = -r;
    return {r, q};
  endfunction

  function automatic int latency_of(input logic [1:0] o, input logic [31:0] y);
    if (!o[1]) return MUL_CYCLES;
    return (y == 32'd0) ? DIVZ_LAT : DIV_LAT;
  endfunction

  // Driver: accept in cycle 0, scramble operands while busy, then score the result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic keep_valid);
    logic [63:0] e;
    int n;
    int lat;
    lat = latency_of(o, y);
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    valid = 1'b1; op = o; a = x; b = y;
    #1;
    check("ok_accept", 64'(ok), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      a = $urandom;
      b = $urandom;
      op = 2'($urandom_range(0, 3));
      #1;
      n++;
    end while (!ok && n < 100);
    check("latency", 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check("hi", 64'(hi), 64'(e[63:32]));
    check("lo", 64'(lo), 64'(e[31:0]));
    prev_hi = e[63:32];
    prev_lo = e[31:0];
    if (!keep_valid) valid = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; valid = 1'b0; op = 2'b00; a = '0; b = '0; hold = 1'b0; flush = 1'b0;
    prev_hi = '0; prev_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_ok", 64'(ok), 64'd1);
    reset = 1'b0;

    // Directed arithmetic cases
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
    do_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0);

    // Hold the DIV result for three extra cycles, then back-to-back MULTU
    do_op(2'b10, 32'd100, 32'd7, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; #1;
      check("hold_ok", 64'(ok), 64'd1);
      check("hold_hi", 64'(hi), 64'(prev_hi));
      check("hold_lo", 64'(lo), 64'(prev_lo));
      if (i == 2) hold = 1'b0;
    end
    do_op(2'b01, 32'd2, 32'd3, 1'b0);

    // Random ops, a quarter of them with a zero divisor
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_op(ro, ra, rb, 1'b0);
    end

    // Flush in cycle 10 of a DIV
    @(posedge clk); #1;
    valid = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1; #1;
    end
    check("busy_ok", 64'(ok), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    check("flush_ok", 64'(ok), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    #1;
    check("post_flush_ok", 64'(ok), 64'd1);
    check("flush_hi", 64'(hi), 64'(prev_hi));
    check("flush_lo", 64'(lo), 64'(prev_lo));
    repeat (40) @(posedge clk);
    #1;
    check("flush_late_hi", 64'(hi), 64'(prev_hi));
    check("flush_late_lo", 64'(lo), 64'(prev_lo));
    check("flush_late_ok", 64'(ok), 64'd1);

    // Reset mid-multiply, after a non-zero result is showing
    do_op(2'b00, 32'd5, 32'd7, 1'b0);
    @(posedge clk); #1;
    valid = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0;
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_ok", 64'(ok), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("after_rst_lo", 64'(lo), 64'd0);
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
